// File: rtl/ysyx_23060332_exu_mc.sv
// Multi-cycle execute unit: single-cycle ALU/jump/branch ops plus an optional iterative
// RV32M multiply/divide, with valid/ready handshakes and a one-deep result register.
module ysyx_23060332_exu_mc #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit HAS_MDU    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            op,
  input  logic [XLEN-1:0]       op1,
  input  logic [XLEN-1:0]       op2,
  input  logic [XLEN-1:0]       op1_jump,
  input  logic [XLEN-1:0]       op2_jump,
  input  logic                  reg_wen_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       wdata,
  output logic [REG_ADDR_W-1:0] waddr_o,
  output logic                  reg_wen_o,
  output logic                  jump_en,
  output logic [XLEN-1:0]       jump_addr
);

  localparam int SHW  = $clog2(XLEN);
  localparam int CNTW = $clog2(XLEN + 1);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_AND    = 5'd2;
  localparam logic [4:0] OP_OR     = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_SLL    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_SLT    = 5'd8;
  localparam logic [4:0] OP_SLTU   = 5'd9;
  localparam logic [4:0] OP_JUMP   = 5'd10;
  localparam logic [4:0] OP_BEQ    = 5'd11;
  localparam logic [4:0] OP_BNE    = 5'd12;
  localparam logic [4:0] OP_BLT    = 5'd13;
  localparam logic [4:0] OP_BGE    = 5'd14;
  localparam logic [4:0] OP_BLTU   = 5'd15;
  localparam logic [4:0] OP_BGEU   = 5'd16;
  localparam logic [4:0] OP_MUL    = 5'd17;
  localparam logic [4:0] OP_MULH   = 5'd18;
  localparam logic [4:0] OP_MULHSU = 5'd19;
  localparam logic [4:0] OP_MULHU  = 5'd20;
  localparam logic [4:0] OP_DIV    = 5'd21;
  localparam logic [4:0] OP_DIVU   = 5'd22;
  localparam logic [4:0] OP_REM    = 5'd23;
  localparam logic [4:0] OP_REMU   = 5'd24;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CNTW-1:0] count_reg, count_next;

  logic accept, is_mdu, is_div, start_mdu, wen_ok;

  assign in_ready  = (state_reg == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept    = in_valid && in_ready;
  assign is_mdu    = (op >= OP_MUL) && (op <= OP_REMU);
  assign is_div    = (op >= OP_DIV);
  assign start_mdu = accept && is_mdu && HAS_MDU;
  assign wen_ok    = reg_wen_i && (waddr_i != '0);

  // ---------------- single-cycle datapath ----------------
  logic [XLEN-1:0] add_res, sub_res, jsum, alu_wdata, alu_jaddr;
  logic            alu_wen, alu_jump, eq, lt, ltu;
  logic [SHW-1:0]  shamt;

  assign add_res = op1 + op2;
  assign sub_res = op1 - op2;
  assign jsum    = op1_jump + op2_jump;
  assign eq      = (op1 == op2);
  assign lt      = ($signed(op1) < $signed(op2));
  assign ltu     = (op1 < op2);
  assign shamt   = op2[SHW-1:0];

  always_comb begin
    alu_wdata = '0;
    alu_wen   = 1'b0;
    alu_jump  = 1'b0;
    alu_jaddr = '0;
    case (op)
      OP_ADD:  begin alu_wdata = add_res;                         alu_wen = wen_ok; end
      OP_SUB:  begin alu_wdata = sub_res;                         alu_wen = wen_ok; end
      OP_AND:  begin alu_wdata = op1 & op2;                       alu_wen = wen_ok; end
      OP_OR:   begin alu_wdata = op1 | op2;                       alu_wen = wen_ok; end
      OP_XOR:  begin alu_wdata = op1 ^ op2;                       alu_wen = wen_ok; end
      OP_SLL:  begin alu_wdata = op1 << shamt;                    alu_wen = wen_ok; end
      OP_SRL:  begin alu_wdata = op1 >> shamt;                    alu_wen = wen_ok; end
      OP_SRA:  begin alu_wdata = $signed(op1) >>> shamt;          alu_wen = wen_ok; end
      OP_SLT:  begin alu_wdata = {{(XLEN-1){1'b0}}, lt};          alu_wen = wen_ok; end
      OP_SLTU: begin alu_wdata = {{(XLEN-1){1'b0}}, ltu};         alu_wen = wen_ok; end
      OP_JUMP: begin
        alu_wdata = add_res;
        alu_wen   = wen_ok;
        alu_jump  = 1'b1;
        alu_jaddr = {jsum[XLEN-1:1], 1'b0};
      end
      OP_BEQ:  begin alu_jump = eq;   alu_jaddr = jsum; end
      OP_BNE:  begin alu_jump = !eq;  alu_jaddr = jsum; end
      OP_BLT:  begin alu_jump = lt;   alu_jaddr = jsum; end
      OP_BGE:  begin alu_jump = !lt;  alu_jaddr = jsum; end
      OP_BLTU: begin alu_jump = ltu;  alu_jaddr = jsum; end
      OP_BGEU: begin alu_jump = !ltu; alu_jaddr = jsum; end
      // Reached only when the MDU is absent: retire with zero data.
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_wen = wen_ok;
      default: ;
    endcase
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        if (start_mdu) begin
          state_next = BUSY;
          count_next = CNTW'(XLEN);
        end
      end
      BUSY: begin
        count_next = count_reg - CNTW'(1);
        if (count_reg == CNTW'(1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) begin
      state_next = IDLE;
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // ---------------- iterative MUL/DIV ----------------
  // Both units work on magnitudes; hi/lo form the 2*XLEN product, or remainder/quotient.
  logic [XLEN-1:0]       md_a_reg, md_hi_reg, md_lo_reg, md_op1_reg;
  logic [4:0]            md_op_reg;
  logic                  md_neg_reg, md_neg_rem_reg, md_div_zero_reg, md_is_div_reg;
  logic [REG_ADDR_W-1:0] md_waddr_reg;
  logic                  md_wen_reg;

  logic            op1_signed, op2_signed, op1_neg, op2_neg;
  logic [XLEN-1:0] mag1, mag2;
  logic [XLEN:0]   mul_sum, rem_shift, div_diff;

  assign op1_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign op2_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign op1_neg    = op1_signed && op1[XLEN-1];
  assign op2_neg    = op2_signed && op2[XLEN-1];
  assign mag1       = op1_neg ? -op1 : op1;
  assign mag2       = op2_neg ? -op2 : op2;

  assign mul_sum   = {1'b0, md_hi_reg} + (md_lo_reg[0] ? {1'b0, md_a_reg} : {(XLEN+1){1'b0}});
  assign rem_shift = {md_hi_reg, md_lo_reg[XLEN-1]};
  assign div_diff  = rem_shift - {1'b0, md_a_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      md_a_reg        <= '0;
      md_hi_reg       <= '0;
      md_lo_reg       <= '0;
      md_op1_reg      <= '0;
      md_op_reg       <= '0;
      md_neg_reg      <= 1'b0;
      md_neg_rem_reg  <= 1'b0;
      md_div_zero_reg <= 1'b0;
      md_is_div_reg   <= 1'b0;
      md_waddr_reg    <= '0;
      md_wen_reg      <= 1'b0;
    end else if (start_mdu) begin
      md_a_reg        <= is_div ? mag2 : mag1;
      md_lo_reg       <= is_div ? mag1 : mag2;
      md_hi_reg       <= '0;
      md_op1_reg      <= op1;
      md_op_reg       <= op;
      md_neg_reg      <= op1_neg ^ op2_neg;
      md_neg_rem_reg  <= op1_neg;
      md_div_zero_reg <= (op2 == '0);
      md_is_div_reg   <= is_div;
      md_waddr_reg    <= waddr_i;
      md_wen_reg      <= wen_ok;
    end else if (state_reg == BUSY) begin
      if (md_is_div_reg) begin
        if (!div_diff[XLEN]) begin
          md_hi_reg <= div_diff[XLEN-1:0];
          md_lo_reg <= {md_lo_reg[XLEN-2:0], 1'b1};
        end else begin
          md_hi_reg <= rem_shift[XLEN-1:0];
          md_lo_reg <= {md_lo_reg[XLEN-2:0], 1'b0};
        end
      end else begin
        md_hi_reg <= mul_sum[XLEN:1];
        md_lo_reg <= {mul_sum[0], md_lo_reg[XLEN-1:1]};
      end
    end
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, mdu_wdata;

  assign prod     = {md_hi_reg, md_lo_reg};
  assign prod_fix = md_neg_reg ? -prod : prod;
  // Signed overflow needs no special case: |q| = 2^(XLEN-1) with positive sign wraps correctly.
  assign quot_fix = md_div_zero_reg ? {XLEN{1'b1}} : (md_neg_reg ? -md_lo_reg : md_lo_reg);
  assign rem_fix  = md_div_zero_reg ? md_op1_reg : (md_neg_rem_reg ? -md_hi_reg : md_hi_reg);

  always_comb begin
    mdu_wdata = '0;
    case (md_op_reg)
      OP_MUL:                        mdu_wdata = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  mdu_wdata = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               mdu_wdata = quot_fix;
      OP_REM, OP_REMU:               mdu_wdata = rem_fix;
      default:                       mdu_wdata = '0;
    endcase
  end

  // ---------------- result register ----------------
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid <= 1'b0;
      wdata     <= '0;
      waddr_o   <= '0;
      reg_wen_o <= 1'b0;
      jump_en   <= 1'b0;
      jump_addr <= '0;
    end else if (accept && !start_mdu) begin
      out_valid <= 1'b1;
      wdata     <= alu_wdata;
      waddr_o   <= waddr_i;
      reg_wen_o <= alu_wen;
      jump_en   <= alu_jump;
      jump_addr <= alu_jaddr;
    end else if (state_reg == DONE) begin
      out_valid <= 1'b1;
      wdata     <= mdu_wdata;
      waddr_o   <= md_waddr_reg;
      reg_wen_o <= md_wen_reg;
      jump_en   <= 1'b0;
      jump_addr <= '0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      wdata     <= '0;
      waddr_o   <= '0;
      reg_wen_o <= 1'b0;
      jump_en   <= 1'b0;
      jump_addr <= '0;
    end
  end

endmodule

// File: tb/tb_ysyx_23060332_exu_mc.sv
// Bench for ysyx_23060332_exu_mc: directed vectors, handshake scenarios and randomized ops
// checked against an arithmetic reference model.
module tb_ysyx_23060332_exu_mc;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  op;
  logic [31:0] op1, op2, op1_jump, op2_jump, wdata, jump_addr;
  logic        reg_wen_i, reg_wen_o, jump_en;
  logic [4:0]  waddr_i, waddr_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ysyx_23060332_exu_mc #(.XLEN(32), .REG_ADDR_W(5), .HAS_MDU(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .op1(op1), .op2(op2), .op1_jump(op1_jump), .op2_jump(op2_jump),
    .reg_wen_i(reg_wen_i), .waddr_i(waddr_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .wdata(wdata), .waddr_o(waddr_o), .reg_wen_o(reg_wen_o),
    .jump_en(jump_en), .jump_addr(jump_addr)
  );

  typedef struct packed {
    logic [31:0] wdata;
    logic        wen;
    logic        jen;
    logic [31:0] jaddr;
    logic [7:0]  lat;
    logic        cmp_w;
    logic        cmp_j;
  } exp_t;

  // Reference: RISC-V semantics evaluated with 64-bit integer arithmetic.
  function automatic exp_t model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ja, input logic [31:0] jb,
                                 input logic w, input logic [4:0] wa);
    exp_t   e;
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic   wok;
    e = '0;
    e.lat = 8'd1;
    e.cmp_w = 1'b1;
    wok = w && (wa != 5'd0);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    if (o <= 5'd10 || (o >= 5'd17 && o <= 5'd24)) e.wen = wok;
    if (o >= 5'd17 && o <= 5'd24) e.lat = 8'd34;
    case (o)
      5'd0:  e.wdata = a + b;
      5'd1:  e.wdata = a - b;
      5'd2:  e.wdata = a & b;
      5'd3:  e.wdata = a | b;
      5'd4:  e.wdata = a ^ b;
      5'd5:  e.wdata = a << b[4:0];
      5'd6:  e.wdata = a >> b[4:0];
      5'd7:  e.wdata = 32'(sa >>> b[4:0]);
      5'd8:  e.wdata = (sa < sb) ? 32'd1 : 32'd0;
      5'd9:  e.wdata = (ua < ub) ? 32'd1 : 32'd0;
      5'd10: begin
        e.wdata = a + b; e.jen = 1'b1; e.cmp_j = 1'b1;
        e.jaddr = (ja + jb) & 32'hFFFF_FFFE;
      end
      5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16: begin
        e.cmp_w = 1'b0; e.cmp_j = 1'b1; e.jaddr = ja + jb;
        case (o)
          5'd11:   e.jen = (a == b);
          5'd12:   e.jen = (a != b);
          5'd13:   e.jen = (sa < sb);
          5'd14:   e.jen = (sa >= sb);
          5'd15:   e.jen = (ua < ub);
          default: e.jen = (ua >= ub);
        endcase
      end
      5'd17: begin p = 64'(ua * ub); e.wdata = p[31:0];  end
      5'd18: begin p = 64'(sa * sb); e.wdata = p[63:32]; end
      5'd19: begin p = 64'(sa * ub); e.wdata = p[63:32]; end
      5'd20: begin p = 64'(ua * ub); e.wdata = p[63:32]; end
      5'd21: e.wdata = (b == 0) ? 32'hFFFF_FFFF :
                       (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      5'd22: e.wdata = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd23: e.wdata = (b == 0) ? a :
                       (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
      5'd24: e.wdata = (b == 0) ? a : a % b;
      default: e.cmp_w = 1'b0;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] edges [8] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'd2, 32'd7, 32'hFFFF_FFF9};
    if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  task automatic drive(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ja, input logic [31:0] jb,
                       input logic w, input logic [4:0] wa);
    op = o; op1 = a; op2 = b; op1_jump = ja; op2_jump = jb; reg_wen_i = w; waddr_i = wa;
  endtask

  // Offer the driven op, wait for acceptance, then count cycles until out_valid.
  task automatic run_op(output int lat);
    int guard = 0;
    in_valid = 1'b1;
    #1;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, wdata, waddr_o, reg_wen_o, jump_en, jump_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%b wdata=%h waddr=%0d wen=%b jen=%b jaddr=%h, want all 0",
               out_valid, wdata, waddr_o, reg_wen_o, jump_en, jump_addr);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [4:0]  t_op [15] = '{5'd0, 5'd10, 5'd13, 5'd18, 5'd20, 5'd17, 5'd21, 5'd23,
                               5'd21, 5'd23, 5'd21, 5'd23, 5'd0, 5'd14, 5'd27};
    logic [31:0] t_a  [15] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'h8000_0000,
                               32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd3,
                               32'hFFFF_FFFF, 32'd5};
    logic [31:0] t_b  [15] = '{32'd1, 32'd4, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
                               32'd4, 32'd0, 32'd6};
    logic [31:0] t_w  [15] = '{32'h8000_0000, 32'h8000_0004, 32'd0, 32'h4000_0000,
                               32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000,
                               32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'd0};
    logic [4:0]  t_rd [15] = '{5'd5, 5'd1, 5'd2, 5'd3, 5'd4, 5'd6, 5'd7, 5'd8, 5'd9,
                               5'd10, 5'd11, 5'd12, 5'd0, 5'd13, 5'd14};
    exp_t e;
    int   lat;
    for (int i = 0; i < 15; i++) begin
      drive(t_op[i], t_a[i], t_b[i], (t_op[i] == 5'd10) ? 32'h8000_1001 : 32'h100,
            (t_op[i] == 5'd10) ? 32'd0 : 32'h21, 1'b1, t_rd[i]);
      e = model(t_op[i], t_a[i], t_b[i], op1_jump, op2_jump, 1'b1, t_rd[i]);
      run_op(lat);
      $display("directed op=%0d a=%h b=%h -> lat=%0d wdata=%h wen=%b jen=%b jaddr=%h",
               t_op[i], t_a[i], t_b[i], lat, wdata, reg_wen_o, jump_en, jump_addr);
      n_cmp++;
      if (lat !== int'(e.lat)) begin
        n_err++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, e.lat);
      end
      n_cmp++;
      if (t_op[i] != 5'd13 && t_op[i] != 5'd14 && t_op[i] != 5'd27 && wdata !== t_w[i]) begin
        n_err++; $display("FAIL dir_wdata[%0d]: got %h want %h", i, wdata, t_w[i]);
      end
      n_cmp++;
      if (reg_wen_o !== e.wen || jump_en !== e.jen || waddr_o !== t_rd[i]) begin
        n_err++;
        $display("FAIL dir_ctrl[%0d]: got wen=%b jen=%b waddr=%0d want wen=%b jen=%b waddr=%0d",
                 i, reg_wen_o, jump_en, waddr_o, e.wen, e.jen, t_rd[i]);
      end
      n_cmp++;
      if (e.cmp_j && jump_addr !== e.jaddr) begin
        n_err++; $display("FAIL dir_jaddr[%0d]: got %h want %h", i, jump_addr, e.jaddr);
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(5'd0, 32'(i), 32'd100, 32'd0, 32'd0, 1'b1, 5'(i + 1));
      in_valid = 1'b1;
      @(posedge clk); #1;
      $display("b2b i=%0d wdata=%h valid=%b", i, wdata, out_valid);
      n_cmp++;
      if (out_valid !== 1'b1 || wdata !== 32'(i + 100) || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b[%0d]: got valid=%b wdata=%h in_ready=%b want 1 %h 1",
                 i, out_valid, wdata, in_ready, 32'(i + 100));
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(5'd0, 32'd10, 32'd20, 32'd0, 32'd0, 1'b1, 5'd7);
    in_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    drive(5'd1, 32'd100, 32'd1, 32'd0, 32'd0, 1'b1, 5'd8);
    #1;
    for (int i = 0; i < 5; i++) begin
      $display("bp hold cycle=%0d valid=%b wdata=%h in_ready=%b", i, out_valid, wdata, in_ready);
      n_cmp++;
      if (out_valid !== 1'b1 || wdata !== 32'd30 || waddr_o !== 5'd7 || reg_wen_o !== 1'b1 ||
          in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got valid=%b wdata=%h waddr=%0d wen=%b in_ready=%b want 1 1e 7 1 0",
                 i, out_valid, wdata, waddr_o, reg_wen_o, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || wdata !== 32'd99 || waddr_o !== 5'd8) begin
      n_err++;
      $display("FAIL bp_second: got valid=%b wdata=%h waddr=%0d want 1 63 8", out_valid, wdata, waddr_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || wdata !== 32'd0) begin
      n_err++; $display("FAIL bp_clear: got valid=%b wdata=%h want 0 0", out_valid, wdata);
    end
  endtask

  task automatic test_flush_offer();
    drive(5'd0, 32'd1, 32'd2, 32'd0, 32'd0, 1'b1, 5'd3);
    in_valid = 1'b1; flush = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_offer_ready: got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_offer_taken: got valid=%b want 0", out_valid); end
  endtask

  task automatic test_flush_busy();
    int seen = 0;
    out_ready = 1'b1;
    drive(5'd21, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b1, 5'd4);
    in_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_busy_ready_low: got %b want 0", in_ready); end
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_busy_idle: got in_ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    $display("flush_busy result cycles seen=%0d", seen);
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL flush_busy_no_result: got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_random();
    exp_t        e;
    int          lat;
    logic [4:0]  o, wa;
    logic [31:0] a, b, ja, jb;
    logic        w;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      o = 5'($urandom_range(0, 31));
      a = pick(); b = pick(); ja = $urandom; jb = $urandom;
      w = 1'($urandom_range(0, 1)); wa = 5'($urandom_range(0, 31));
      drive(o, a, b, ja, jb, w, wa);
      e = model(o, a, b, ja, jb, w, wa);
      run_op(lat);
      $display("rand i=%0d op=%0d a=%h b=%h -> lat=%0d wdata=%h wen=%b jen=%b jaddr=%h",
               i, o, a, b, lat, wdata, reg_wen_o, jump_en, jump_addr);
      n_cmp++;
      if (lat !== int'(e.lat) || waddr_o !== wa || reg_wen_o !== e.wen || jump_en !== e.jen) begin
        n_err++;
        $display("FAIL rand_ctrl[%0d] op=%0d: got lat=%0d waddr=%0d wen=%b jen=%b want %0d %0d %b %b",
                 i, o, lat, waddr_o, reg_wen_o, jump_en, e.lat, wa, e.wen, e.jen);
      end
      n_cmp++;
      if ((e.cmp_w && wdata !== e.wdata) || (e.cmp_j && jump_addr !== e.jaddr)) begin
        n_err++;
        $display("FAIL rand_data[%0d] op=%0d a=%h b=%h: got wdata=%h jaddr=%h want %h %h",
                 i, o, a, b, wdata, jump_addr, e.wdata, e.jaddr);
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    int seen = 0;
    out_ready = 1'b0;
    drive(5'd10, 32'd8, 32'd8, 32'h1234_5679, 32'd0, 1'b1, 5'd9);
    run_op(lat);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, wdata, waddr_o, reg_wen_o, jump_en, jump_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_held: got valid=%b wdata=%h waddr=%0d wen=%b jen=%b jaddr=%h want all 0",
               out_valid, wdata, waddr_o, reg_wen_o, jump_en, jump_addr);
    end
    out_ready = 1'b1;
    drive(5'd17, 32'd123, 32'd456, 32'd0, 32'd0, 1'b1, 5'd2);
    in_valid = 1'b1;
    #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, wdata, waddr_o, reg_wen_o, jump_en, jump_addr} !== '0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_mul: got valid=%b wdata=%h jen=%b in_ready=%b want 0 0 0 1",
               out_valid, wdata, jump_en, in_ready);
    end
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    $display("reset_mid_mul result cycles seen=%0d", seen);
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL reset_mid_mul_no_result: got %0d want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_flush_offer();
    test_flush_busy();
    test_random();
    test_reset_mid_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
